// File: rtl/hi_tag_tx_15_pkg.sv
// Shared HF-path types and constants for the ISO15693 tag response transmitter.
package hi_tag_tx_15_pkg;

    typedef enum logic [1:0] {SEG_OFF, SEG_P32, SEG_P28} seg_t;

    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF, ST_GAP} state_t;

    localparam int unsigned P32_PERIOD = 32;
    localparam int unsigned P28_PERIOD = 28;

    localparam logic [9:0] BIT_P32 = 10'd8;
    localparam logic [9:0] BIT_P28 = 10'd9;
    localparam logic [9:0] SOF_P32 = 10'd24;
    localparam logic [9:0] SOF_P28 = 10'd27;
    localparam logic [9:0] OFF_BIT = 10'd256;
    localparam logic [9:0] OFF_SOF = 10'd768;

    typedef struct packed {
        seg_t       typ;
        logic [9:0] len;
    } seg_cmd_t;

    // Unmodulated half of a symbol: plain off time, or the fc/28 carrier in dual mode
    function automatic seg_cmd_t quiet_seg(input logic dual, input logic long_seg);
        seg_cmd_t c;
        if (dual) begin
            c.typ = SEG_P28;
            c.len = long_seg ? SOF_P28 : BIT_P28;
        end else begin
            c.typ = SEG_OFF;
            c.len = long_seg ? OFF_SOF : OFF_BIT;
        end
        return c;
    endfunction

    function automatic seg_cmd_t pulse_seg(input logic [9:0] n);
        seg_cmd_t c;
        c.typ = SEG_P32;
        c.len = n;
        return c;
    endfunction

    // Segment to play for a given symbol step; SOF ends with logic 1, EOF starts with logic 0
    function automatic seg_cmd_t seg_sel(input state_t st, input logic [1:0] step,
                                         input logic bit_val, input logic dual);
        seg_cmd_t c;
        c = pulse_seg(BIT_P32);
        case (st)
            ST_SOF: begin
                case (step)
                    2'd0:    c = quiet_seg(dual, 1'b1);
                    2'd1:    c = pulse_seg(SOF_P32);
                    2'd2:    c = quiet_seg(dual, 1'b0);
                    default: c = pulse_seg(BIT_P32);
                endcase
            end
            ST_DATA: begin
                if (step[0] ^ bit_val) c = quiet_seg(dual, 1'b0);
            end
            ST_EOF: begin
                case (step)
                    2'd0:    c = pulse_seg(BIT_P32);
                    2'd1:    c = quiet_seg(dual, 1'b0);
                    2'd2:    c = pulse_seg(SOF_P32);
                    default: c = quiet_seg(dual, 1'b1);
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic last_step(input state_t st, input logic [1:0] step);
        return (st == ST_DATA) ? (step == 2'd1) : (step == 2'd3);
    endfunction

endpackage

// File: rtl/hi_tag_15_seg.sv
// Segment player: plays one OFF / P32 / P28 segment per start strobe.
// P28 generation is present only when HI_TAG_TX_15_DUAL_SC_EN is defined.
module hi_tag_15_seg
    import hi_tag_tx_15_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  seg_t       typ,
    input  logic [9:0] len,
    output logic       mod,
    output logic       seg_done
);

    localparam logic [4:0] P32_LAST = 5'(P32_PERIOD - 1);
    localparam logic [4:0] P32_HIGH = 5'(P32_PERIOD / 2);
`ifdef HI_TAG_TX_15_DUAL_SC_EN
    localparam logic [4:0] P28_LAST = 5'(P28_PERIOD - 1);
    localparam logic [4:0] P28_HIGH = 5'(P28_PERIOD / 2);
`endif

    logic       active;
    seg_t       cur;
    logic [9:0] remaining;
    logic [4:0] phase;
    logic       period_end;

    // Subcarrier phase decode: OFF segments count single clocks
    always_comb begin
        period_end = 1'b1;
        mod        = 1'b0;
        case (cur)
            SEG_P32: begin
                period_end = (phase == P32_LAST);
                mod        = active & (phase < P32_HIGH);
            end
`ifdef HI_TAG_TX_15_DUAL_SC_EN
            SEG_P28: begin
                period_end = (phase == P28_LAST);
                mod        = active & (phase < P28_HIGH);
            end
`endif
            default: ;
        endcase
        seg_done = active & period_end & (remaining == 10'd1);
    end

    // Segment counters; a start always restarts the period phase at zero
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            cur       <= SEG_OFF;
            remaining <= '0;
            phase     <= '0;
        end else if (start) begin
            active    <= 1'b1;
            cur       <= typ;
            remaining <= len;
            phase     <= '0;
        end else if (active) begin
            if (seg_done) begin
                active <= 1'b0;
            end else if (period_end) begin
                phase     <= '0;
                remaining <= remaining - 10'd1;
            end else begin
                phase <= phase + 5'd1;
            end
        end
    end

endmodule

// File: rtl/hi_tag_tx_15.sv
// ISO15693 tag response transmitter: SOF/data/EOF framing and Manchester
// load modulation on the 13.56 MHz negedge domain.
// Define HI_TAG_TX_15_DUAL_SC_EN to enable dual-subcarrier coding.
module hi_tag_tx_15
    import hi_tag_tx_15_pkg::*;
#(
    parameter int unsigned TX_GAP = 64
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       dual_sc,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       mod_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [15:0] GAP_LAST = 16'(TX_GAP - 1);

    state_t     state;
    logic [1:0] step;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       shift_last;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_valid;
    logic       dual_q;
    logic       rdy_en;
    logic [15:0] gap_cnt;

    logic       dual_in;
    logic       xfer;
    logic       seg_done;
    logic       cur_last;
    logic       hold_move;
    logic       launch;
    state_t     l_state;
    logic [1:0] l_step;
    logic       l_bit;
    logic       launch_dual;
    logic       load_bus;
    logic       shift_adv;
    logic       to_eof;
    logic       set_underrun;
    logic       frame_end;
    seg_cmd_t   cmd;

`ifdef HI_TAG_TX_15_DUAL_SC_EN
    assign dual_in = dual_sc;
`else
    logic unused_dual_sc;
    assign unused_dual_sc = dual_sc;
    assign dual_in        = 1'b0;
`endif

    assign cur_last  = last_step(state, step);
    // Holding byte moves to the shift register at SOF end or at a byte boundary
    assign hold_move = seg_done & cur_last & hold_valid &
                       ((state == ST_SOF) |
                        ((state == ST_DATA) & (bit_cnt == 3'd7) & ~shift_last));
    // Ready also on the move cycle so a new byte can refill without a bubble
    assign tx_ready  = rdy_en & ((state == ST_IDLE) |
                       (((state == ST_SOF) | (state == ST_DATA)) & (~hold_valid | hold_move)));
    assign xfer      = tx_valid & tx_ready;
    assign busy      = (state != ST_IDLE);

    // Next-segment sequencing, evaluated on the last clock of the playing segment
    always_comb begin
        launch       = 1'b0;
        l_state      = state;
        l_step       = step;
        l_bit        = shift[0];
        load_bus     = 1'b0;
        shift_adv    = 1'b0;
        to_eof       = 1'b0;
        set_underrun = 1'b0;
        frame_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    launch  = 1'b1;
                    l_state = ST_SOF;
                    l_step  = 2'd0;
                end
            end
            ST_SOF, ST_DATA, ST_EOF: begin
                if (seg_done) begin
                    if (!cur_last) begin
                        launch = 1'b1;
                        l_step = step + 2'd1;
                    end else if (state == ST_SOF) begin
                        launch  = 1'b1;
                        l_state = ST_DATA;
                        l_step  = 2'd0;
                        l_bit   = hold_data[0];
                    end else if (state == ST_DATA) begin
                        launch = 1'b1;
                        l_step = 2'd0;
                        if (bit_cnt != 3'd7) begin
                            l_bit     = shift[1];
                            shift_adv = 1'b1;
                        end else if (shift_last) begin
                            l_state = ST_EOF;
                            to_eof  = 1'b1;
                        end else if (hold_valid) begin
                            l_bit = hold_data[0];
                        end else if (xfer) begin
                            l_bit    = tx_data[0];
                            load_bus = 1'b1;
                        end else begin
                            l_state      = ST_EOF;
                            to_eof       = 1'b1;
                            set_underrun = 1'b1;
                        end
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        done = frame_end;
    end

    assign launch_dual = (state == ST_IDLE) ? dual_in : dual_q;
    assign cmd         = seg_sel(l_state, l_step, l_bit, launch_dual);

    hi_tag_15_seg u_seg (
        .clk      (ck_1356meg),
        .rst_n    (rst_n),
        .start    (launch),
        .typ      (cmd.typ),
        .len      (cmd.len),
        .mod      (mod_out),
        .seg_done (seg_done)
    );

    // Frame FSM, byte buffering and status flags
    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            step       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            shift_last <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            dual_q     <= 1'b0;
            underrun   <= 1'b0;
            rdy_en     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (hold_move) hold_valid <= 1'b0;
            if (xfer && !load_bus) begin
                hold_data  <= tx_data;
                hold_last  <= tx_last;
                hold_valid <= 1'b1;
            end
            if (launch) begin
                state <= l_state;
                step  <= l_step;
            end
            if (state == ST_IDLE && xfer) begin
                dual_q   <= dual_in;
                underrun <= 1'b0;
            end
            if (hold_move) begin
                shift      <= hold_data;
                shift_last <= hold_last;
                bit_cnt    <= '0;
            end else if (load_bus) begin
                shift      <= tx_data;
                shift_last <= tx_last;
                bit_cnt    <= '0;
            end else if (shift_adv) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (to_eof) hold_valid <= 1'b0;
            if (set_underrun) underrun <= 1'b1;
            if (frame_end) begin
                gap_cnt <= '0;
                step    <= '0;
                state   <= (TX_GAP == 0) ? ST_IDLE : ST_GAP;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
                if (gap_cnt == GAP_LAST) state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_hi_tag_tx_15.sv
// Self-checking bench for hi_tag_tx_15: randomized frames against a
// waveform model built from the ISO15693 symbol definitions.
module tb_hi_tag_tx_15;

    localparam int GAP = 64;

`ifdef HI_TAG_TX_15_DUAL_SC_EN
    localparam bit DUAL_BUILT = 1'b1;
`else
    localparam bit DUAL_BUILT = 1'b0;
`endif

    logic       ck = 1'b1;
    logic       rst_n = 1'b0;
    logic       dual_sc = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       mod_out;
    logic       busy;
    logic       done;
    logic       underrun;

    int n_vec = 0;
    int n_err = 0;

    logic       exp_wave[$];
    logic [7:0] frame_bytes[4];

    hi_tag_tx_15 #(.TX_GAP(GAP)) dut (
        .ck_1356meg (ck),
        .rst_n      (rst_n),
        .dual_sc    (dual_sc),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .mod_out    (mod_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 ck = ~ck;

    // ---------------- waveform model ----------------
    task automatic add_periods(input int period, input int n);
        for (int k = 0; k < n; k++)
            for (int c = 0; c < period; c++)
                exp_wave.push_back(c < period / 2);
    endtask

    task automatic add_off(input int c);
        repeat (c) exp_wave.push_back(1'b0);
    endtask

    task automatic add_quiet(input bit dual, input bit long_seg);
        if (dual) add_periods(28, long_seg ? 27 : 9);
        else      add_off(long_seg ? 768 : 256);
    endtask

    task automatic add_logic(input bit dual, input bit b);
        if (b) begin
            add_quiet(dual, 1'b0);
            add_periods(32, 8);
        end else begin
            add_periods(32, 8);
            add_quiet(dual, 1'b0);
        end
    endtask

    task automatic build_expected(input bit dual, input int nbytes);
        logic [7:0] byte_v;
        exp_wave.delete();
        add_quiet(dual, 1'b1);
        add_periods(32, 24);
        add_logic(dual, 1'b1);
        for (int i = 0; i < nbytes; i++) begin
            byte_v = frame_bytes[i];
            for (int b = 0; b < 8; b++) add_logic(dual, byte_v[b]);
        end
        add_logic(dual, 1'b0);
        add_periods(32, 24);
        add_quiet(dual, 1'b1);
    endtask

    // ---------------- frame driver + checker ----------------
    task automatic run_frame(input string name, input bit dual_in, input int nbytes,
                             input bit mark_last, input int max_delay, input bit exp_under);
        bit   eff_dual;
        int   idx;
        int   delay;
        bit   started;
        bit   finished;
        int   cyc;
        logic rec[$];
        int   exp_len;
        int   first_bad;
        int   first_hi;
        int   gap_hi;
        bit   rdy_seen;
        bit   done_stuck;
        int   n;

        eff_dual = dual_in & DUAL_BUILT;
        build_expected(eff_dual, nbytes);
        exp_len  = eff_dual ? (4064 + 508 * 8 * nbytes) : (4096 + 512 * 8 * nbytes);
        idx      = 0;
        delay    = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
        started  = 0;
        finished = 0;
        cyc      = 0;

        while (!finished && cyc < exp_len + 20000) begin
            @(posedge ck);
            cyc++;
            if (started) begin
                if (rec.size() == 0) begin
                    n_vec++;
                    if (busy !== 1'b1 || underrun !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s start: busy=%b underrun=%b, want busy=1 underrun=0",
                                 name, busy, underrun);
                    end
                end
                rec.push_back(mod_out);
                if (done === 1'b1) finished = 1;
            end
            if (idx < nbytes && delay == 0) begin
                tx_valid = 1'b1;
                tx_data  = frame_bytes[idx];
                tx_last  = mark_last && (idx == nbytes - 1);
                dual_sc  = dual_in;
            end else begin
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                tx_data  = 8'($urandom);
                if (started) dual_sc = 1'($urandom);
                if (delay > 0) delay--;
            end
            #4;
            if (tx_valid && tx_ready === 1'b1) begin
                idx++;
                started = 1;
                delay   = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
            end
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;

        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL %s done_timeout: no done after %0d clocks, want done at %0d",
                     name, cyc, exp_len);
        end

        n_vec++;
        if (rec.size() != exp_len) begin
            n_err++;
            $display("FAIL %s length: got %0d clocks, want %0d", name, rec.size(), exp_len);
        end

        first_bad = -1;
        n = (rec.size() < exp_wave.size()) ? rec.size() : exp_wave.size();
        for (int i = 0; i < n; i++) begin
            if (rec[i] !== exp_wave[i]) begin
                first_bad = i;
                break;
            end
        end
        n_vec++;
        if (first_bad >= 0) begin
            n_err++;
            $display("FAIL %s wave: first diff at clock %0d, got %b, want %b",
                     name, first_bad + 1, rec[first_bad], exp_wave[first_bad]);
        end

        first_hi = -1;
        foreach (rec[i]) begin
            if (rec[i] === 1'b1) begin
                first_hi = i;
                break;
            end
        end
        n_vec++;
        if (first_hi != (eff_dual ? 0 : 768)) begin
            n_err++;
            $display("FAIL %s first_high: got offset %0d, want %0d",
                     name, first_hi, eff_dual ? 0 : 768);
        end

        gap_hi     = 0;
        rdy_seen   = 0;
        done_stuck = 0;
        for (int k = 0; k < GAP + 100; k++) begin
            @(posedge ck);
            if (k == 0 && done !== 1'b0) done_stuck = 1;
            if (busy !== 1'b1) break;
            gap_hi++;
            if (tx_ready !== 1'b0) rdy_seen = 1;
        end

        n_vec++;
        if (done_stuck) begin
            n_err++;
            $display("FAIL %s done_pulse: done still high after final clock, want 0", name);
        end
        n_vec++;
        if (gap_hi != GAP) begin
            n_err++;
            $display("FAIL %s gap: busy high %0d clocks after done, want %0d", name, gap_hi, GAP);
        end
        n_vec++;
        if (rdy_seen) begin
            n_err++;
            $display("FAIL %s gap_ready: tx_ready=1 during gap, want 0", name);
        end
        n_vec++;
        if (tx_ready !== 1'b1 || underrun !== exp_under) begin
            n_err++;
            $display("FAIL %s idle: tx_ready=%b underrun=%b, want tx_ready=1 underrun=%b",
                     name, tx_ready, underrun, exp_under);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(posedge ck);
        n_vec++;
        if ({mod_out, tx_ready, busy, done, underrun} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_hold: mod/ready/busy/done/underrun=%b, want 00000",
                     {mod_out, tx_ready, busy, done, underrun});
        end
        rst_n = 1'b1;
        @(posedge ck);
        n_vec++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || mod_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b busy=%b mod=%b, want 1 0 0",
                     tx_ready, busy, mod_out);
        end
    endtask

    task automatic test_single_byte;
        frame_bytes[0] = 8'h01;
        run_frame("single_01", 1'b0, 1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_dual_byte;
        frame_bytes[0] = 8'hFE;
        run_frame("dual_fe", 1'b1, 1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) frame_bytes[i] = 8'($urandom);
        run_frame("stream3", 1'b0, 3, 1'b1, 0, 1'b0);
    endtask

    task automatic test_underrun;
        frame_bytes[0] = 8'($urandom);
        run_frame("underrun", 1'b0, 1, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random;
        int nb;
        nb = int'($urandom_range(2, 1));
        for (int i = 0; i < nb; i++) frame_bytes[i] = 8'($urandom);
        run_frame("random", 1'($urandom), nb, 1'b1, 1500, 1'b0);
    endtask

    task automatic test_reset_mid;
        bit found;
        @(posedge ck);
        tx_data  = 8'hFF;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        dual_sc  = 1'b0;
        #4;
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_start: tx_ready=%b, want 1", tx_ready);
        end
        @(posedge ck);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        found    = 0;
        for (int k = 1; k < 4000; k++) begin
            @(posedge ck);
            if (k > 2100 && mod_out === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL mid_wait: mod_out never high in data, want 1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (mod_out !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async: mod=%b ready=%b busy=%b, want 0 0 0",
                     mod_out, tx_ready, busy);
        end
        @(posedge ck);
        rst_n = 1'b1;
        @(posedge ck);
        n_vec++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || mod_out !== 1'b0 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: ready=%b busy=%b mod=%b underrun=%b, want 1 0 0 0",
                     tx_ready, busy, mod_out, underrun);
        end
    endtask

    task automatic test_after_reset;
        frame_bytes[0] = 8'($urandom);
        run_frame("after_reset", 1'b0, 1, 1'b1, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_dual_byte;
        test_back_to_back;
        test_underrun;
        test_random;
        test_reset_mid;
        test_after_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hi_tag_tx_15.md
# hi_tag_tx_15

Tag-side ISO15693 response transmitter for the 13.56 MHz path, the counterpart of the HF reader's subcarrier demodulator. It accepts response bytes from the ARM-facing logic over a valid/ready byte stream. It frames them with SOF/EOF, Manchester-codes them LSB first, and produces the load-modulation signal. The signal is either a single subcarrier (fc/32, 423.75 kHz) or the dual subcarrier (fc/32 and fc/28, 484.28 kHz). The tag-simulation top level routes `mod_out` to the antenna load switch.

## Interface
- `TX_GAP`, 64: idle clocks after EOF before a new frame may start (0 allowed).
- `ck_1356meg  in  1`: 13.56 MHz carrier clock; all logic on negedge, as in the rest of the HF path.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `dual_sc  in  1`: 1 = dual-subcarrier coding. Sampled only on the frame-start cycle.
- `tx_data  in  8`: response byte, sent LSB first.
- `tx_valid  in  1`: `tx_data`/`tx_last` valid.
- `tx_last  in  1`: byte is the last of the frame; EOF follows it.
- `tx_ready  out  1`: holding register empty. A transfer occurs when `tx_valid & tx_ready`.
- `mod_out  out  1`: load modulation, 1 = load on.
- `busy  out  1`: high from SOF start through end of `TX_GAP`.
- `done  out  1`: one-cycle pulse on the last EOF clock.
- `underrun  out  1`: sticky flag; set when a byte is needed and none is held. Cleared at next frame start.

## Operation
- Segment primitives:
  - `P32(n)`: n periods of 32 clocks, mod high for clocks 0–15 of each period.
  - `P28(n)`: n periods of 28 clocks, mod high for clocks 0–13.
  - `OFF(c)`: c clocks, mod low.
- Single-subcarrier coding (`dual_sc`=0):
  - Logic 0 = P32(8), OFF(256).
  - Logic 1 = OFF(256), P32(8).
  - SOF = OFF(768), P32(24), logic 1.
  - EOF = logic 0, P32(24), OFF(768).
- Dual-subcarrier coding (`dual_sc`=1):
  - Logic 0 = P32(8), P28(9).
  - Logic 1 = P28(9), P32(8).
  - SOF = P28(27), P32(24), logic 1.
  - EOF = logic 0, P32(24), P28(27).
- Bit lengths: 512 clocks single, 508 dual. SOF and EOF are each 2048 clocks single, 2032 dual.
- FSM states and transitions:
  - IDLE → SOF on a transfer. `dual_sc` is latched and `underrun` is cleared.
  - SOF → DATA. The holding byte moves to the shift register at SOF end.
  - DATA → DATA on each bit boundary, 8 bits per byte.
  - DATA → EOF after bit 7 of a byte flagged `tx_last`.
  - DATA → EOF with `underrun` set when bit 7 ends and the holding register is empty.
  - EOF → GAP.
  - GAP → IDLE after `TX_GAP` clocks.
- Buffering:
  - One holding register plus one shift register.
  - `tx_ready` is high in IDLE, and in SOF/DATA whenever the holding register is empty.
  - `tx_ready` is low in EOF and GAP.
  - The holding register empties on the cycle its byte moves to the shift register. A transfer on that same cycle refills it; there is no lost byte and no bubble.
- Subcarrier period counters restart at the start of every segment. There is no phase carry-over between segments.

## Timing
- Reset values: `mod_out`=0, `tx_ready`=0 while `rst_n` low and 1 on the first clock after release, `busy`=0, `done`=0, `underrun`=0. The FSM resets to IDLE.
- Reset asserted mid-frame forces `mod_out` low immediately (asynchronous) and discards all buffered bytes.
- If a transfer occurs at cycle N in IDLE:
  - `busy` rises at N+1.
  - First SOF clock is N+1.
  - Single: first `mod_out` high at N+1+768.
  - Dual: first `mod_out` high at N+1.
- Frame length for k bytes: single 4096+512·8k clocks, dual 4064+508·8k clocks.
- `done` pulses on the frame's final clock.
- `busy` falls `TX_GAP` clocks after `done`.
- `tx_last` on a byte while an earlier byte is still in the shift register is honoured when that byte reaches bit 7.

## Configuration
- `HI_TAG_TX_15_DUAL_SC_EN` defined:
  - The fc/28 generator and dual-subcarrier sequencing are compiled in.
  - `dual_sc` behaves as above.
- Undefined:
  - The P28 logic is removed.
  - `dual_sc` is ignored and treated as 0. All frames use single-subcarrier coding.

## Structure
- The shared HF package holds:
  - Segment-type enum: OFF, P32, P28.
  - FSM state enum.
  - Constants: 32, 28, 8, 9, 24, 27 pulse counts/periods; 256 and 768 off lengths.
- Sub-module `hi_tag_15_seg` holds the segment player. Inputs are type, count and a start strobe; outputs are `mod` and a one-cycle `seg_done`. The top-level FSM issues segment sequences.

## Test plan
- Single subcarrier, one byte 0x01 with `tx_last` → frame of 8192 clocks:
  - `mod_out` low for 768 clocks, then 24 P32 pulses.
  - Bit 0 = logic 1, bits 1–7 = logic 0.
  - `done` at clock 8192.
- Dual subcarrier, byte 0xFE with `tx_last` → P28(27) first (first high at N+1), frame length 8128 clocks, bit 0 = P32(8)+P28(9).
- Three bytes streamed, second presented exactly on the shift-load cycle → no gap between bytes; frame is 16384 clocks single.
- `tx_valid` withheld after the first byte (no `tx_last`) → EOF follows bit 7, `underrun`=1, cleared on the next frame start.
- `rst_n` pulsed low mid-DATA while `mod_out`=1 → `mod_out`=0 asynchronously; after release, IDLE with `tx_ready`=1.
- Macro undefined, `dual_sc`=1 → waveform identical to the single-subcarrier case.
